// File: rtl/ptc_pwr_pkg.sv
// Shared types and constants for the crate power sequencer.
// State codes and status bit positions are visible to software.
package ptc_pwr_pkg;

    localparam int N_WIB = 6;
    localparam int N_OT = 3;

    // Alert vector order: 3V3, 2V5, WIB feeds, 12 V input, over-temp
    localparam int AL_3V3 = 0;
    localparam int AL_2V5 = 1;
    localparam int AL_VP12 = 2;
    localparam int AL_VIN = AL_VP12 + N_WIB;
    localparam int AL_OT = AL_VIN + 1;
    localparam int N_ALERT = AL_OT + N_OT;

    typedef enum logic [2:0] {
        ST_OFF  = 3'd0,
        ST_UP3  = 3'd1,
        ST_UP2  = 3'd2,
        ST_RUN  = 3'd3,
        ST_DOWN = 3'd4
    } pwr_state_e;

    localparam int STS_EN_3V3 = 0;
    localparam int STS_EN_2V5 = 1;
    localparam int STS_VP12 = 2;
    localparam int STS_WFAULT = 8;
    localparam int STS_GFAULT = 14;
    localparam int STS_OTL = 15;
    localparam int STS_STATE = 16;

    function automatic logic [N_WIB-1:0] lowest_one(input logic [N_WIB-1:0] v);
        return v & (~v + N_WIB'(1));
    endfunction

endpackage

// File: rtl/alert_debounce.sv
// Two-flop synchronizer plus run-length debounce for an active-low alert.
// The flag is registered once more after the run counter saturates.
module alert_debounce #(
    parameter int DEBOUNCE = 16
) (
    input  logic clk_axi,
    input  logic resetn,
    input  logic alert_n,
    output logic flag
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE);

    logic s1;
    logic s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk_axi or negedge resetn) begin
        if (!resetn) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            cnt  <= '0;
            flag <= 1'b0;
        end else begin
            s1 <= ~alert_n;
            s2 <= s1;
            if (!s2) begin
                cnt  <= '0;
                flag <= 1'b0;
            end else begin
                if (cnt != CMAX) cnt <= cnt + CW'(1);
                flag <= (cnt == CMAX);
            end
        end
    end

endmodule

// File: rtl/ptc_power_sequencer.sv
// Crate power sequencer: LV rail ramp, staggered WIB 12 V feeds,
// debounced alerts with latched faults and a status word.
module ptc_power_sequencer
    import ptc_pwr_pkg::*;
#(
    parameter int LV_DELAY = 100000,
    parameter int STAGGER = 50000,
    parameter int DEBOUNCE = 16,
    parameter int CNT_W = 24
) (
    input  logic        clk_axi,
    input  logic        resetn,
    input  logic        lv_on_req,
    input  logic [5:0]  wib_on_req,
    input  logic        fault_clr,
    input  logic        vp3v3_alert,
    input  logic        vp2v5_alert,
    input  logic [6:0]  vp12_alert,
    input  logic [2:0]  over_temp,
    output logic        en_3v3,
    output logic        en_2v5,
    output logic [5:0]  vp12_en,
    output logic        over_temp_led,
    output logic [31:0] status
);

    localparam logic [CNT_W-1:0] LV_LOAD = CNT_W'(LV_DELAY - 1);
    localparam logic [CNT_W-1:0] ST_LOAD = CNT_W'(STAGGER - 1);

    pwr_state_e state;
    logic [CNT_W-1:0] cnt;
    logic [N_WIB-1:0] wib_fault;
    logic global_fault;
    logic ot_latch;

    logic [N_ALERT-1:0] pin_n;
    logic [N_ALERT-1:0] dflag;

    assign pin_n = {over_temp, vp12_alert, vp2v5_alert, vp3v3_alert};

    for (genvar g = 0; g < N_ALERT; g++) begin : g_db
        alert_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
            .clk_axi (clk_axi),
            .resetn  (resetn),
            .alert_n (pin_n[g]),
            .flag    (dflag[g])
        );
    end

    logic [N_WIB-1:0] wflag;
    logic [N_WIB-1:0] wib_fault_nxt;
    logic [N_WIB-1:0] keep;
    logic [N_WIB-1:0] cand;
    logic ot_src;
    logic g_src;
    logic g_clr;
    logic shut;

    always_comb begin
        wflag  = dflag[AL_VP12 +: N_WIB];
        ot_src = |dflag[AL_OT +: N_OT];
        g_src  = dflag[AL_3V3] | dflag[AL_2V5] | dflag[AL_VIN] | ot_src;
        g_clr  = fault_clr && (state == ST_OFF) && !g_src;
        shut   = !lv_on_req || global_fault || g_src;
        // A new alert always wins over a clear in the same cycle
        wib_fault_nxt = (wib_fault & ~({N_WIB{fault_clr}} & ~wflag)) | wflag;
        keep = vp12_en & wib_on_req & ~wflag;
        cand = wib_on_req & ~vp12_en & ~wib_fault & ~wflag;
    end

    always_ff @(posedge clk_axi or negedge resetn) begin
        if (!resetn) begin
            state        <= ST_OFF;
            cnt          <= '0;
            en_3v3       <= 1'b0;
            en_2v5       <= 1'b0;
            vp12_en      <= '0;
            wib_fault    <= '0;
            global_fault <= 1'b0;
            ot_latch     <= 1'b0;
        end else begin
            wib_fault    <= wib_fault_nxt;
            global_fault <= (global_fault && !g_clr) || g_src;
            ot_latch     <= (ot_latch && !g_clr) || ot_src;
            vp12_en      <= (state == ST_RUN) ? keep : '0;
            unique case (state)
                ST_OFF: begin
                    if (lv_on_req && !global_fault) begin
                        state  <= ST_UP3;
                        en_3v3 <= 1'b1;
                        cnt    <= LV_LOAD;
                    end
                end
                ST_UP3: begin
                    if (shut) begin
                        state <= ST_DOWN;
                        cnt   <= LV_LOAD;
                    end else if (cnt == '0) begin
                        state  <= ST_UP2;
                        en_2v5 <= 1'b1;
                        cnt    <= LV_LOAD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_UP2: begin
                    if (shut) begin
                        state  <= ST_DOWN;
                        en_2v5 <= 1'b0;
                        cnt    <= LV_LOAD;
                    end else if (cnt == '0) begin
                        state <= ST_RUN;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    // cnt is the stagger timer here; it arrives at zero
                    if (shut) begin
                        state   <= ST_DOWN;
                        en_2v5  <= 1'b0;
                        vp12_en <= '0;
                        cnt     <= LV_LOAD;
                    end else if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (|cand) begin
                        vp12_en <= keep | lowest_one(cand);
                        cnt     <= ST_LOAD;
                    end
                end
                ST_DOWN: begin
                    if (cnt == '0) begin
                        state  <= ST_OFF;
                        en_3v3 <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state   <= ST_OFF;
                    en_3v3  <= 1'b0;
                    en_2v5  <= 1'b0;
                    vp12_en <= '0;
                end
            endcase
        end
    end

    assign over_temp_led = ot_latch;

    always_comb begin
        status = '0;
        status[STS_EN_3V3] = en_3v3;
        status[STS_EN_2V5] = en_2v5;
        status[STS_VP12 +: N_WIB] = vp12_en;
        status[STS_WFAULT +: N_WIB] = wib_fault;
        status[STS_GFAULT] = global_fault;
        status[STS_OTL] = ot_latch;
        status[STS_STATE +: 3] = state;
    end

endmodule

// File: tb/tb_ptc_power_sequencer.sv
// Directed bench for ptc_power_sequencer with a timestamp-based
// reference model compared every cycle plus literal spot checks.
module tb_ptc_power_sequencer;

    localparam int LVD = 8;
    localparam int STG = 4;
    localparam int DEB = 3;

    logic clk_axi = 1'b0;
    logic resetn = 1'b0;
    logic lv_on_req = 1'b0;
    logic [5:0] wib_on_req = '0;
    logic fault_clr = 1'b0;
    logic vp3v3_alert = 1'b1;
    logic vp2v5_alert = 1'b1;
    logic [6:0] vp12_alert = 7'h7F;
    logic [2:0] over_temp = 3'b111;
    logic en_3v3;
    logic en_2v5;
    logic [5:0] vp12_en;
    logic over_temp_led;
    logic [31:0] status;

    int n_assert = 0;
    int n_fail = 0;
    logic chk_on = 1'b0;

    ptc_power_sequencer #(
        .LV_DELAY (LVD),
        .STAGGER  (STG),
        .DEBOUNCE (DEB),
        .CNT_W    (24)
    ) dut (
        .clk_axi       (clk_axi),
        .resetn        (resetn),
        .lv_on_req     (lv_on_req),
        .wib_on_req    (wib_on_req),
        .fault_clr     (fault_clr),
        .vp3v3_alert   (vp3v3_alert),
        .vp2v5_alert   (vp2v5_alert),
        .vp12_alert    (vp12_alert),
        .over_temp     (over_temp),
        .en_3v3        (en_3v3),
        .en_2v5        (en_2v5),
        .vp12_en       (vp12_en),
        .over_temp_led (over_temp_led),
        .status        (status)
    );

    always #5 clk_axi = ~clk_axi;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: modes 0 OFF, 1 UP3, 2 UP2, 3 RUN, 4 DOWN.
    // Phases end at absolute cycle stamps; an alert is acted on once the
    // pin had DEB+1 consecutive low samples ending three edges earlier.
    int kc = 0;
    int m_mode = 0;
    int t_next = 0;
    int wib_ok = 0;
    logic [5:0] m_en = '0;
    logic [5:0] m_wf = '0;
    logic m_gf = 1'b0;
    logic m_ot = 1'b0;
    int run1[12];
    int run2[12];
    int run3[12];
    logic [11:0] pins_n;
    logic [11:0] act;
    logic [5:0] wact;
    logic [5:0] cand;
    logic oact, gact, gclr, shut;
    bit found;

    assign pins_n = {over_temp, vp12_alert, vp2v5_alert, vp3v3_alert};

    always @(posedge clk_axi or negedge resetn) begin
        if (!resetn) begin
            kc = 0;
            m_mode = 0;
            t_next = 0;
            wib_ok = 0;
            m_en = '0;
            m_wf = '0;
            m_gf = 1'b0;
            m_ot = 1'b0;
            for (int i = 0; i < 12; i++) begin
                run1[i] = 0;
                run2[i] = 0;
                run3[i] = 0;
            end
        end else begin
            kc++;
            for (int i = 0; i < 12; i++) begin
                act[i] = (run3[i] >= DEB + 1);
                run3[i] = run2[i];
                run2[i] = run1[i];
                run1[i] = pins_n[i] ? 0 : run1[i] + 1;
            end
            wact = act[7:2];
            oact = |act[11:9];
            gact = act[0] | act[1] | act[8] | oact;
            gclr = fault_clr && (m_mode == 0) && !gact;
            shut = !lv_on_req || m_gf || gact;
            cand = wib_on_req & ~m_en & ~m_wf & ~wact;
            case (m_mode)
                0: if (lv_on_req && !m_gf) begin
                    m_mode = 1;
                    t_next = kc + LVD;
                end
                1, 2: if (shut) begin
                    m_mode = 4;
                    t_next = kc + LVD;
                end else if (kc == t_next) begin
                    if (m_mode == 1) begin
                        m_mode = 2;
                        t_next = kc + LVD;
                    end else begin
                        m_mode = 3;
                        wib_ok = kc + 1;
                    end
                end
                3: if (shut) begin
                    m_mode = 4;
                    t_next = kc + LVD;
                    m_en = '0;
                end else begin
                    m_en &= wib_on_req & ~wact;
                    if (kc >= wib_ok && cand != 0) begin
                        found = 0;
                        for (int i = 0; i < 6; i++)
                            if (cand[i] && !found) begin
                                m_en[i] = 1'b1;
                                found = 1;
                            end
                        wib_ok = kc + STG;
                    end
                end
                4: if (kc == t_next) m_mode = 0;
                default: m_mode = 0;
            endcase
            m_wf = (m_wf & ~(fault_clr ? ~wact : 6'h00)) | wact;
            m_gf = (m_gf && !gclr) || gact;
            m_ot = (m_ot && !gclr) || oact;
        end
    end

    logic [40:0] exp_bundle;
    logic [40:0] dut_bundle;
    logic m_e3, m_e2;

    always_comb begin
        m_e3 = (m_mode != 0);
        m_e2 = (m_mode == 2) || (m_mode == 3);
        exp_bundle = {13'd0, 3'(m_mode), m_ot, m_gf, m_wf, m_en, m_e2, m_e3,
                      m_ot, m_e3, m_e2, m_en};
        dut_bundle = {status, over_temp_led, en_3v3, en_2v5, vp12_en};
    end

    always @(negedge clk_axi)
        if (chk_on) check("model_cycle", 64'(dut_bundle), 64'(exp_bundle));

    task automatic tick(input int n);
        repeat (n) @(negedge clk_axi);
    endtask

    task automatic pulse_clr();
        fault_clr = 1'b1;
        tick(1);
        fault_clr = 1'b0;
    endtask

    int r3, r2, f2, f3, fell;
    int rw[6];
    int exp_rw[6];
    logic [5:0] vp_at_fall;
    logic [2:0] st_at_fall;
    bit ok;

    initial begin
        exp_rw = '{18, 22, 26, 30, 34, 38};
        tick(3);
        chk_on = 1'b1;
        check("reset_status", 64'(status), 64'h0);
        check("reset_en", 64'({en_3v3, en_2v5, vp12_en, over_temp_led}), 64'h0);
        resetn = 1'b1;
        tick(2);

        // Power-up ramp
        lv_on_req = 1'b1;
        wib_on_req = 6'h3F;
        r3 = -1;
        r2 = -1;
        for (int i = 0; i < 6; i++) rw[i] = -1;
        for (int c = 1; c <= 42; c++) begin
            @(posedge clk_axi);
            #1;
            if (en_3v3 && r3 < 0) r3 = c;
            if (en_2v5 && r2 < 0) r2 = c;
            for (int i = 0; i < 6; i++)
                if (vp12_en[i] && rw[i] < 0) rw[i] = c;
        end
        check("rise_3v3", 64'(r3), 64'd1);
        check("rise_2v5", 64'(r2), 64'd9);
        for (int i = 0; i < 6; i++)
            check($sformatf("rise_wib%0d", i), 64'(rw[i]), 64'(exp_rw[i]));
        check("run_state", 64'(status[18:16]), 64'd3);
        tick(2);

        // Short WIB alert glitch is ignored
        vp12_alert[2] = 1'b0;
        tick(3);
        vp12_alert[2] = 1'b1;
        tick(8);
        check("short_alert_en", 64'(vp12_en), 64'h3F);
        check("short_alert_fault", 64'(status[13:8]), 64'h0);

        // Sustained WIB alert
        vp12_alert[2] = 1'b0;
        fell = -1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk_axi);
            #1;
            if (!vp12_en[2] && fell < 0) fell = c;
        end
        @(negedge clk_axi);
        vp12_alert[2] = 1'b1;
        check("wib_alert_latency", 64'(fell), 64'd6);
        check("wib_fault2", 64'(status[10]), 64'd1);
        tick(5);
        pulse_clr();
        tick(4);
        check("wib2_recovered", 64'(vp12_en), 64'h3F);
        check("wib2_fault_clr", 64'(status[13:8]), 64'h0);

        // Clear coincident with a new debounced alert
        vp12_alert[0] = 1'b0;
        tick(6);
        pulse_clr();
        check("simul_fault0", 64'(status[8]), 64'd1);
        check("simul_en0", 64'(vp12_en[0]), 64'd0);
        vp12_alert[0] = 1'b1;
        tick(5);
        pulse_clr();
        tick(4);
        check("wib0_recovered", 64'(vp12_en), 64'h3F);

        // Over-temperature shutdown
        over_temp = 3'b101;
        f2 = -1;
        f3 = -1;
        vp_at_fall = 6'h3F;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk_axi);
            #1;
            if (!en_2v5 && f2 < 0) begin
                f2 = c;
                vp_at_fall = vp12_en;
            end
            if (!en_3v3 && f3 < 0) f3 = c;
        end
        check("ot_fall_2v5", 64'(f2), 64'd6);
        check("ot_vp12_same_edge", 64'(vp_at_fall), 64'h0);
        check("ot_fall_3v3", 64'(f3), 64'd14);
        @(negedge clk_axi);
        check("ot_led", 64'(over_temp_led), 64'd1);
        tick(5);
        check("ot_stay_off", 64'({status[18:16], en_3v3}), 64'h0);
        pulse_clr();
        tick(2);
        check("ot_latch_held", 64'(status[15:14]), 64'h3);
        over_temp = 3'b111;
        tick(5);
        pulse_clr();
        tick(2);
        check("ot_restart_3v3", 64'(en_3v3), 64'd1);
        check("ot_led_clr", 64'(over_temp_led), 64'd0);

        // Shutdown request during UP2
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk_axi);
            ok = en_2v5;
        end
        check("wait_up2", 64'(ok), 64'd1);
        tick(2);
        lv_on_req = 1'b0;
        f2 = -1;
        f3 = -1;
        st_at_fall = 3'd0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk_axi);
            #1;
            if (!en_2v5 && f2 < 0) begin
                f2 = c;
                st_at_fall = status[18:16];
            end
            if (!en_3v3 && f3 < 0) f3 = c;
        end
        check("sd_fall_2v5", 64'(f2), 64'd0);
        check("sd_down_state", 64'(st_at_fall), 64'd4);
        check("sd_fall_3v3", 64'(f3), 64'd8);
        tick(2);

        // Asynchronous reset with four feeds on
        lv_on_req = 1'b1;
        wib_on_req = 6'h0F;
        ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk_axi);
            ok = (vp12_en == 6'h0F);
        end
        check("wait_4wib", 64'(ok), 64'd1);
        @(posedge clk_axi);
        #3;
        resetn = 1'b0;
        #1;
        check("async_rst_en", 64'({en_3v3, en_2v5, vp12_en}), 64'h0);
        check("async_rst_status", 64'(status), 64'h0);
        lv_on_req = 1'b0;
        tick(3);
        resetn = 1'b1;
        tick(3);
        check("post_rst_status", 64'(status), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ptc_power_sequencer.md
# ptc_power_sequencer

Power sequencer for the crate's low-voltage rails and six WIB 12 V feeds. It sits between the register file and the board pins. It consumes control bits from the read/write register bank and drives EN_3V3, EN_2V5 and VP12_EN0..5. It debounces the power-monitor ALERT and OVER_TEMP inputs, latches faults, sheds load, and returns a status word for the read-only register bank.

## Interface
- LV_DELAY, 100000, cycles between rail steps (1 ms at 100 MHz)
- STAGGER, 50000, minimum cycles between successive WIB turn-ons
- DEBOUNCE, 16, consecutive synchronized-asserted cycles before an alert counts
- CNT_W, 24, width of the delay counter; must satisfy 2^CNT_W > max(LV_DELAY, STAGGER)

Ports:
- clk_axi  in  1  AXI clock; the only clock
- resetn  in  1  asynchronous, active-low reset
- lv_on_req  in  1  level request: low-voltage rails on
- wib_on_req  in  6  level request per WIB 12 V feed
- fault_clr  in  1  single-cycle pulse that clears latched faults
- vp3v3_alert, vp2v5_alert  in  1 each  rail monitor alerts, active-low, asynchronous
- vp12_alert  in  7  bits 0..5 are per-WIB feed alerts; bit 6 is the shared 12 V input alert; active-low, asynchronous
- over_temp  in  3  OVER_TEMP0..2, active-low, asynchronous
- en_3v3, en_2v5  out  1 each  rail enables
- vp12_en  out  6  WIB feed enables
- over_temp_led  out  1  high while the over-temperature latch is set
- status  out  32  status word for the read-only register bank

## Operation
- Every alert and over_temp input passes through a 2-FF synchronizer and then a debounce counter.
  - The debounced flag rises after DEBOUNCE consecutive asserted samples.
  - A single deasserted sample clears the counter and the flag.
- Reset values:
  - All outputs 0.
  - State OFF.
  - Counters 0.
  - All latches clear.
- States and transitions:
  - OFF: all enables low. Goes to UP3 when lv_on_req=1 and global_fault=0.
  - UP3: en_3v3=1. After LV_DELAY cycles, goes to UP2.
  - UP2: en_2v5=1. After LV_DELAY cycles, goes to RUN.
  - RUN: WIB feeds are managed as described below.
  - DOWN: vp12_en=0 and en_2v5=0; en_3v3 stays 1. After LV_DELAY cycles, goes to OFF with en_3v3=0.
- From UP3, UP2 or RUN, the block goes to DOWN when lv_on_req=0 or global_fault=1.
- global_fault latches on any of:
  - debounced vp3v3_alert or vp2v5_alert
  - debounced vp12_alert[6]
  - any debounced over_temp; this also sets ot_latch
- WIB turn-on in RUN:
  - A candidate is a bit i with wib_on_req[i]=1, vp12_en[i]=0 and wib_fault[i]=0.
  - When the stagger counter is 0 and a candidate exists, the block enables the lowest-index candidate and reloads the counter to STAGGER-1.
  - The stagger counter is 0 on entry to RUN.
- WIB turn-off and per-WIB faults:
  - wib_on_req[i]=0 clears vp12_en[i] on the next edge.
  - Debounced vp12_alert[i] (i<6) clears vp12_en[i] on the next edge and sets wib_fault[i]. This applies in any state.
- fault_clr:
  - Clears each wib_fault[i] whose debounced alert is currently inactive.
  - Clears global_fault and ot_latch only in OFF, and only if all global sources are inactive.
  - In any other state it has no effect on global_fault or ot_latch.
- Simultaneous events:
  - A fault and a turn-on candidate in the same cycle: the fault wins.
  - fault_clr and a new debounced alert in the same cycle: the latch remains set.
- resetn asserted mid-sequence drops all enables at once, asynchronously.
- status bit map:
  - [0] en_3v3
  - [1] en_2v5
  - [7:2] vp12_en
  - [13:8] wib_fault
  - [14] global_fault
  - [15] ot_latch
  - [18:16] state
  - [31:19] 0
- over_temp_led = ot_latch.

## Timing
- All outputs are registered.
- OFF to UP3: en_3v3 rises on the edge after lv_on_req is sampled high.
- en_2v5 rises exactly LV_DELAY cycles after en_3v3.
- The first vp12_en bit rises LV_DELAY+1 cycles after en_2v5.
- Later vp12_en bits rise every STAGGER cycles while candidates remain.
- Alert latency: from the first clk_axi edge that samples an asserted pin to the deasserted enable is exactly DEBOUNCE+3 cycles.
- DOWN: vp12_en and en_2v5 fall on the edge entering DOWN; en_3v3 falls LV_DELAY cycles later.
- lv_on_req reasserted during DOWN has no effect until OFF is reached.
- status reflects register state with zero added latency.

## Structure
- Package ptc_pwr_pkg holds:
  - the state encoding: OFF=0, UP3=1, UP2=2, RUN=3, DOWN=4
  - the status bit-position constants
  - the WIB count (6) and the over-temp count (3)
- Sub-module alert_debounce (2-FF synchronizer plus DEBOUNCE counter, parameter DEBOUNCE) is instantiated 12 times.
- The top holds the FSM, the shared delay/stagger counter and the fault latches.

## Test plan
Bench parameters: LV_DELAY=8, STAGGER=4, DEBOUNCE=3.
- Power-up: lv_on_req=1, wib_on_req=6'h3F → en_3v3 at cycle 1, en_2v5 at 9, vp12_en bits 0..5 at 18, 22, 26, 30, 34, 38; status[18:16]=3.
- WIB alert: in RUN, drive vp12_alert[2] low for 3 cycles → no action. Drive it low for 10 cycles → vp12_en[2]=0 exactly 6 cycles after first sampling and status[10]=1. Release, pulse fault_clr → wib_fault[2]=0, and bit 2 re-enables after the stagger.
- Over-temperature: over_temp[1] low in RUN → vp12_en=0 and en_2v5=0 on the same edge, en_3v3=0 8 cycles later, over_temp_led=1. lv_on_req stays high but the block stays in OFF. fault_clr while the pin is still asserted → ot_latch remains set. Release the pin, then fault_clr → the block restarts.
- Shutdown request: lv_on_req dropped mid-UP2 → DOWN entered, en_2v5 falls at once, en_3v3 falls 8 cycles later.
- Reset mid-RUN: resetn low with 4 WIBs on → all outputs 0 immediately, without waiting for a clock edge, and status=0.
- Simultaneous events: fault_clr on the same cycle as a new debounced vp12_alert[0] → wib_fault[0] stays 1.
